// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: ROM port, redirect input, and the IF/ID hand-off to decode.
interface instruction_fetch_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_instr;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              id_ready;
  logic              if_valid;
  logic [31:0]       if_instr;
  logic [31:0]       if_pc;
  logic              halted;

  modport master (
    output rom_addr, if_valid, if_instr, if_pc, halted,
    input  rom_instr, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  rom_addr, if_valid, if_instr, if_pc, halted,
    output rom_instr, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, combinational ROM lookup, IF/ID register
// with decode back-pressure, redirect flush and halt detection.
module instruction_fetch #(
  parameter int          ADDR_W     = 5,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input logic              clk,
  input logic              rst_n,
  instruction_fetch_if.master fif
);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_p0;
  logic        vld_p1;
  logic [31:0] instr_p1;
  logic [31:0] pc_p1;

  logic        adv;
  logic        is_halt;
  logic        drain;
  logic [31:0] redirect_aligned;

  assign fif.rom_addr = pc_p0[ADDR_W+1:2];
  assign fif.if_valid = vld_p1;
  assign fif.if_instr = instr_p1;
  assign fif.if_pc    = pc_p1;
  assign fif.halted   = (state_q == S_HALT);

  assign redirect_aligned = fif.redirect_pc & ~32'd3;

  always_comb begin
    state_d = state_q;
    adv     = (state_q == S_RUN) && (!vld_p1 || fif.id_ready);
    is_halt = (fif.rom_instr == HALT_INSTR);
    // Decode consumed the last instruction while fetch is frozen by a halt.
    drain   = !adv && vld_p1 && fif.id_ready;
    if (fif.redirect_valid) begin
      state_d = S_RUN;
    end else if (adv && is_halt) begin
      state_d = S_HALT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage p0 -> p1: PC advance and IF/ID capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p0    <= RESET_PC;
      vld_p1   <= 1'b0;
      instr_p1 <= NOP_INSTR;
      pc_p1    <= 32'h0;
    end else if (fif.redirect_valid) begin
      pc_p0    <= redirect_aligned;
      vld_p1   <= 1'b0;
      instr_p1 <= NOP_INSTR;
    end else if (adv) begin
      instr_p1 <= fif.rom_instr;
      pc_p1    <= pc_p0;
      vld_p1   <= 1'b1;
      if (!is_halt) begin
        pc_p0 <= pc_p0 + 32'd4;
      end
    end else if (drain) begin
      vld_p1   <= 1'b0;
      instr_p1 <= NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch with a cycle-level reference model
// derived from the fetch rules, plus directed literal scenarios.
module tb_instruction_fetch;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  instruction_fetch_if #(.ADDR_W(5)) fif();

  instruction_fetch #(.ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fif   (fif.master)
  );

  logic [31:0] rom [32];
  assign fif.rom_instr = rom[fif.rom_addr];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural view of fetch (next pc, IF/ID contents, halt flag)
  logic [31:0] m_pc, m_instr, m_ifpc;
  logic        m_valid, m_halted;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 32'h0; m_valid = 1'b0; m_instr = NOP; m_ifpc = 32'h0; m_halted = 1'b0;
    end else begin
      automatic logic take = !m_halted && (!m_valid || fif.id_ready);
      automatic logic [31:0] word = rom[m_pc[6:2]];
      if (fif.redirect_valid) begin
        m_pc = {fif.redirect_pc[31:2], 2'b00};
        m_valid = 1'b0; m_instr = NOP; m_halted = 1'b0;
      end else if (take) begin
        m_instr = word; m_ifpc = m_pc; m_valid = 1'b1;
        if (word == HALT) m_halted = 1'b1;
        else m_pc = m_pc + 32'd4;
      end else if (m_valid && fif.id_ready) begin
        m_valid = 1'b0; m_instr = NOP;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rom_addr", {27'h0, fif.rom_addr}, {27'h0, m_pc[6:2]});
      chk("if_valid", {31'h0, fif.if_valid}, {31'h0, m_valid});
      chk("if_instr", fif.if_instr, m_instr);
      chk("if_pc", fif.if_pc, m_ifpc);
      chk("halted", {31'h0, fif.halted}, {31'h0, m_halted});
      if (fif.if_valid === 1'b1)
        chk("instr_matches_rom", fif.if_instr, rom[fif.if_pc[6:2]]);
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] ins,
                            input logic [31:0] pc, input logic h);
    chk({tag, "_valid"}, {31'h0, fif.if_valid}, {31'h0, v});
    chk({tag, "_instr"}, fif.if_instr, ins);
    chk({tag, "_pc"}, fif.if_pc, pc);
    chk({tag, "_halted"}, {31'h0, fif.halted}, {31'h0, h});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rom[i] = $urandom;
      if (rom[i] == HALT) rom[i] = 32'h0000_0033;
    end
    rom[0] = 32'h0030_0513;
    rom[1] = 32'h0140_00ef;
    rom[5] = HALT;
    fif.redirect_valid = 1'b0;
    fif.redirect_pc    = 32'h0;
    fif.id_ready       = 1'b0;

    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    tick(); tick();
    expect_out("reset", 1'b0, NOP, 32'h0, 1'b0);
    chk("reset_rom_addr", {27'h0, fif.rom_addr}, 32'd0);

    // Streaming
    rst_n = 1'b1; fif.id_ready = 1'b1;
    tick(); expect_out("stream0", 1'b1, 32'h0030_0513, 32'h0, 1'b0);
    tick(); expect_out("stream1", 1'b1, 32'h0140_00ef, 32'h4, 1'b0);

    // Stall with if_pc=4
    fif.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("stall", 1'b1, 32'h0140_00ef, 32'h4, 1'b0);
      chk("stall_rom_addr", {27'h0, fif.rom_addr}, 32'd2);
    end
    fif.id_ready = 1'b1;
    tick(); expect_out("after_stall", 1'b1, rom[2], 32'h8, 1'b0);
    tick(); tick(); tick();
    expect_out("halt", 1'b1, HALT, 32'h14, 1'b1);
    chk("halt_rom_addr", {27'h0, fif.rom_addr}, 32'd5);
    tick(); expect_out("halt_drain", 1'b0, NOP, 32'h14, 1'b1);
    tick(); chk("halt_frozen_rom_addr", {27'h0, fif.rom_addr}, 32'd5);

    // Redirect out of halt, misaligned target
    fif.redirect_valid = 1'b1; fif.redirect_pc = 32'h1B;
    tick(); fif.redirect_valid = 1'b0;
    expect_out("redir", 1'b0, NOP, 32'h14, 1'b0);
    chk("redir_rom_addr", {27'h0, fif.rom_addr}, 32'd6);
    tick(); expect_out("redir_fetch", 1'b1, rom[6], 32'h18, 1'b0);

    // Wrap
    fif.redirect_valid = 1'b1; fif.redirect_pc = 32'h7C;
    tick(); fif.redirect_valid = 1'b0;
    chk("wrap_rom_addr31", {27'h0, fif.rom_addr}, 32'd31);
    tick(); chk("wrap_pc7c", fif.if_pc, 32'h7C);
    chk("wrap_rom_addr0", {27'h0, fif.rom_addr}, 32'd0);
    tick(); expect_out("wrap80", 1'b1, 32'h0030_0513, 32'h80, 1'b0);

    // Reset while halted and stalled
    fif.redirect_valid = 1'b1; fif.redirect_pc = 32'h14;
    tick(); fif.redirect_valid = 1'b0; fif.id_ready = 1'b0;
    tick(); expect_out("rehalt", 1'b1, HALT, 32'h14, 1'b1);
    tick();
    rst_n = 1'b0;
    #1 expect_out("async_reset", 1'b0, NOP, 32'h0, 1'b0);
    chk("async_reset_rom_addr", {27'h0, fif.rom_addr}, 32'd0);
    tick();
    rst_n = 1'b1; fif.id_ready = 1'b1;
    tick(); expect_out("restart", 1'b1, 32'h0030_0513, 32'h0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      fif.id_ready       = ($urandom_range(0, 9) < 7);
      fif.redirect_valid = ($urandom_range(0, 9) == 0);
      fif.redirect_pc    = $urandom_range(0, 255);
      if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
    end

    fif.redirect_valid = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
